sampling_buffer_mc: RTL

- Parametrised, multi-channel, double-buffered successor to the 32-point ADC sampling buffer.
- Captures POINTS samples per channel on sample strobes while arm is high, then publishes the completed frame in a ping-pong bank with a valid/ack handshake.
- Capture into the second bank continues while the consumer (FFT / display path) reads the first.
- Sits between the ADC interface and the FFT/display pipeline.

---
 rtl/sampling_buffer_mc_if.sv | 37 +++
 rtl/sampling_buffer_mc.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/sampling_buffer_mc_if.sv
// sampling_buffer_mc_if
//   Consumer-side bus of the multi-channel sampling buffer: published-frame
//   handshake plus the random-access read port.
//   master : the buffer (drives rd_data, frame_valid, frame_seq)
//   slave  : the consumer, FFT/display path (drives rd_ch, rd_addr, frame_ack)
// Signals:
//   rd_ch       channel select, max(1,$clog2(CHANNELS)) bits
//   rd_addr     sample index, $clog2(POINTS) bits
//   rd_data     published-bank sample, 1-cycle read latency
//   frame_valid published bank holds an unacknowledged frame
//   frame_ack   one-cycle pulse releasing the published bank
//   frame_seq   publish counter, wraps 255->0
interface sampling_buffer_mc_if #(
   parameter int POINTS   = 32,
   parameter int WIDTH    = 12,
   parameter int CHANNELS = 1
);
   localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int AW   = $clog2(POINTS);

   logic [CH_W-1:0]  rd_ch;
   logic [AW-1:0]    rd_addr;
   logic [WIDTH-1:0] rd_data;
   logic             frame_valid;
   logic             frame_ack;
   logic [7:0]       frame_seq;

   modport master (
      input  rd_ch, rd_addr, frame_ack,
      output rd_data, frame_valid, frame_seq
   );

   modport slave (
      output rd_ch, rd_addr, frame_ack,
      input  rd_data, frame_valid, frame_seq
   );
endinterface

// File: rtl/sampling_buffer_mc.sv
// sampling_buffer_mc
//   Multi-channel, double-buffered ADC frame capture. While arm is high,
//   POINTS samples per channel are written into the write bank on sample_en
//   strobes; a completed frame is published by swapping banks, so capture of
//   the next frame proceeds while the consumer reads the previous one.
//   If the consumer still holds an unacknowledged frame at completion, the new
//   frame is dropped and counted instead.
// Optional build macro: SAMPLING_BUFFER_MC_TRIGGER_EN
//   Adds trig_level and a WAIT_TRIG state: capture starts on a rising crossing
//   of trig_level by channel 0, with the crossing sample as index 0.
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous, active-high reset
//   sample_en   one-cycle sample strobe
//   arm         level; high enables capture, low aborts and re-arms
//   adc_in      CHANNELS*WIDTH, channel c at [c*WIDTH +: WIDTH]
//   trig_level  (TRIGGER_EN only) channel-0 rising trigger threshold
//   busy        high while capturing (or waiting for trigger)
//   overrun     sticky, a completed frame was dropped
//   drop_count  dropped frames, saturating at 255
//   bus         sampling_buffer_mc_if master: read port + valid/ack handshake
//
// state      | meaning
// -----------+------------------------------------------------------------
// IDLE       | disarmed; counter at 0
// WAIT_TRIG  | armed, watching channel 0 for a rising crossing (TRIGGER_EN)
// CAPTURE    | writing samples into the write bank
// DONE_HOLD  | single-shot frame finished; waiting for arm to drop
module sampling_buffer_mc #(
   parameter int POINTS     = 32,
   parameter int WIDTH      = 12,
   parameter int CHANNELS   = 1,
   parameter int CONTINUOUS = 0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      sample_en,
   input  logic                      arm,
   input  logic [CHANNELS*WIDTH-1:0] adc_in,
`ifdef SAMPLING_BUFFER_MC_TRIGGER_EN
   input  logic [WIDTH-1:0]          trig_level,
`endif
   output logic                      busy,
   output logic                      overrun,
   output logic [7:0]                drop_count,
   sampling_buffer_mc_if.master      bus
);
   localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int AW   = $clog2(POINTS);
   localparam logic [AW-1:0] LAST_IDX = AW'(POINTS - 1);

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_CAPTURE   = 2'd1,
      ST_DONE_HOLD = 2'd2,
      ST_WAIT_TRIG = 2'd3
   } state_t;

   state_t           state, state_nxt;
   logic [AW-1:0]    count, count_nxt;
   logic             wr_bank;
   logic             wr_en;
   logic [AW-1:0]    wr_addr;
   logic             complete;
   logic             done_q;
   logic             smp;
   logic [WIDTH-1:0] ch_word [CHANNELS];
   logic [WIDTH-1:0] rd_sel;

`ifdef SAMPLING_BUFFER_MC_TRIGGER_EN
   logic [WIDTH-1:0] prev_ch0;
   logic             trig_hit;
   assign trig_hit = (prev_ch0 < trig_level) && (adc_in[WIDTH-1:0] >= trig_level);
`endif

   // The cycle right after a completion is dead for capture, so a strobe
   // there never lands in the freshly restarted frame.
   assign smp = sample_en && arm && !done_q;

   always_comb begin
      state_nxt = state;
      count_nxt = count;
      wr_en     = 1'b0;
      wr_addr   = count;
      complete  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (arm) begin
`ifdef SAMPLING_BUFFER_MC_TRIGGER_EN
               state_nxt = ST_WAIT_TRIG;
`else
               state_nxt = ST_CAPTURE;
`endif
            end
         end
`ifdef SAMPLING_BUFFER_MC_TRIGGER_EN
         ST_WAIT_TRIG: begin
            if (smp && trig_hit) begin
               wr_en     = 1'b1;
               wr_addr   = '0;
               count_nxt = AW'(1);
               state_nxt = ST_CAPTURE;
            end
         end
`endif
         ST_CAPTURE: begin
            if (smp) begin
               wr_en = 1'b1;
               if (count == LAST_IDX) begin
                  complete  = 1'b1;
                  count_nxt = '0;
                  if (CONTINUOUS != 0) begin
`ifdef SAMPLING_BUFFER_MC_TRIGGER_EN
                     state_nxt = ST_WAIT_TRIG;
`else
                     state_nxt = ST_CAPTURE;
`endif
                  end else begin
                     state_nxt = ST_DONE_HOLD;
                  end
               end else begin
                  count_nxt = count + AW'(1);
               end
            end
         end
         default: ;
      endcase
      if (!arm) begin
         state_nxt = ST_IDLE;
         count_nxt = '0;
         wr_en     = 1'b0;
         complete  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= ST_IDLE;
         count           <= '0;
         wr_bank         <= 1'b0;
         done_q          <= 1'b0;
         busy            <= 1'b0;
         overrun         <= 1'b0;
         drop_count      <= '0;
         bus.frame_valid <= 1'b0;
         bus.frame_seq   <= '0;
         bus.rd_data     <= '0;
      end else begin
         state       <= state_nxt;
         count       <= count_nxt;
         done_q      <= complete;
         busy        <= (state_nxt == ST_CAPTURE) || (state_nxt == ST_WAIT_TRIG);
         bus.rd_data <= rd_sel;
         if (complete && (!bus.frame_valid || bus.frame_ack)) begin
            wr_bank         <= ~wr_bank;
            bus.frame_valid <= 1'b1;
            bus.frame_seq   <= bus.frame_seq + 8'd1;
         end else begin
            if (complete) begin
               overrun <= 1'b1;
               if (drop_count != 8'hFF)
                  drop_count <= drop_count + 8'd1;
            end
            if (bus.frame_ack && bus.frame_valid)
               bus.frame_valid <= 1'b0;
         end
      end
   end

`ifdef SAMPLING_BUFFER_MC_TRIGGER_EN
   // Previous sample starts from 0 each time the trigger search is entered.
   always_ff @(posedge clk) begin
      if (rst)
         prev_ch0 <= '0;
      else if (state != ST_WAIT_TRIG && state_nxt == ST_WAIT_TRIG)
         prev_ch0 <= '0;
      else if (state == ST_WAIT_TRIG && smp)
         prev_ch0 <= adc_in[WIDTH-1:0];
   end
`endif

   // One RAM per channel holding both banks; bank select is the address MSB.
   // The published bank is always the one not being written.
   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      logic [WIDTH-1:0] mem [2*POINTS];
      always_ff @(posedge clk) begin
         if (wr_en)
            mem[{wr_bank, wr_addr}] <= adc_in[c*WIDTH +: WIDTH];
      end
      assign ch_word[c] = mem[{~wr_bank, bus.rd_addr}];
   end

   // Unmatched channel selects (rd_ch >= CHANNELS) fall through to zero.
   always_comb begin
      rd_sel = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         if (bus.rd_ch == CH_W'(c))
            rd_sel = ch_word[c];
      end
   end
endmodule
